// File: rtl/prog_line_pkg.sv
// prog_line_pkg: definitions shared by both ends of the phase-delay programming line.
// It holds the frame-format levels, the default number width and bit period,
// and the encoder state encoding. The encoder and the decoder both use these
// values, so the two ends cannot drift apart.
package prog_line_pkg;

    // Frame format: the line rests low, a frame opens with a high start bit,
    // and data is sent MSB first.
    localparam logic START_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b0;
    localparam bit   MSB_FIRST   = 1'b1;

    // Defaults shared by the encoder and the decoder.
    localparam int unsigned DEF_NUM_SIZE = 8;
    localparam int unsigned DEF_BIT_CLKS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/prog_num_encoder_if.sv
// prog_num_encoder_if: request handshake and serial-line status bundle for the encoder.
//   numIn    : program number to send (requester -> encoder)
//   numValid : send request (requester -> encoder)
//   numReady : encoder accepts a request this cycle (encoder -> requester)
//   progOut  : serial program line (encoder -> board)
//   busy     : frame in flight (encoder -> requester)
//   done     : pulse on the last cycle of the final stop bit (encoder -> requester)
interface prog_num_encoder_if
    import prog_line_pkg::*;
#(
    parameter int unsigned NUM_SIZE = DEF_NUM_SIZE
);
    logic [NUM_SIZE-1:0] numIn;
    logic                numValid;
    logic                numReady;
    logic                progOut;
    logic                busy;
    logic                done;

    modport master (
        output numIn, numValid,
        input  numReady, progOut, busy, done
    );

    modport slave (
        input  numIn, numValid,
        output numReady, progOut, busy, done
    );
endinterface

// File: rtl/prog_bit_timer.sv
// prog_bit_timer: bit-period counter that wraps every BIT_CLKS cycles.
//   clk, rst              : clock and asynchronous active-high reset
//   en_i                  : count enable
//   clr_i                 : hold the count at zero (takes priority over en_i)
//   period_end_c_o        : last cycle of the current bit period (combinational)
//   period_near_end_c_o   : second-to-last cycle of the current bit period (combinational)
module prog_bit_timer
    import prog_line_pkg::*;
#(
    parameter int unsigned BIT_CLKS = DEF_BIT_CLKS,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic period_end_c_o,
    output logic period_near_end_c_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(BIT_CLKS - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, hold, or wrap at the end of the period.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign period_end_c_o      = en_i && !clr_i && (cnt_q == CNT_LAST);
    assign period_near_end_c_o = en_i && !clr_i && (cnt_q == CNT_NEAR);
endmodule

// File: rtl/prog_num_encoder.sv
// prog_num_encoder: serializes a program number onto the single-wire program line.
// Frame: a high start bit, NUM_SIZE data bits sent MSB first, then STOP_BITS low
// stop bits. Each bit lasts BIT_CLKS cycles.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of prog_num_encoder_if (numIn/numValid in;
//              numReady/progOut/busy/done out; only numReady is combinational)
module prog_num_encoder
    import prog_line_pkg::*;
#(
    parameter int unsigned NUM_SIZE     = DEF_NUM_SIZE,
    parameter int unsigned BIT_CLKS     = DEF_BIT_CLKS,
    parameter int unsigned BIT_CNT_SIZE = 16,
    parameter int unsigned STOP_BITS    = 2
) (
    input logic               clk,
    input logic               rst,
    prog_num_encoder_if.slave bus
);
    localparam int unsigned IDX_MAX = (NUM_SIZE > STOP_BITS) ? NUM_SIZE : STOP_BITS;
    localparam int unsigned IDX_W   = $clog2(IDX_MAX) + 1;
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(NUM_SIZE - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    enc_state_e          state_q, state_d;
    logic [NUM_SIZE-1:0] shift_q, shift_d, shift_adv;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                prog_out_q, prog_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                period_end;
    logic                period_near_end;

    // The period counter runs in every active state and is held at zero in IDLE.
    prog_bit_timer #(
        .BIT_CLKS (BIT_CLKS),
        .CNT_W    (BIT_CNT_SIZE)
    ) u_bit_timer (
        .clk                 (clk),
        .rst                 (rst),
        .en_i                (state_q != ST_IDLE),
        .clr_i               (state_q == ST_IDLE),
        .period_end_c_o      (period_end),
        .period_near_end_c_o (period_near_end)
    );

    // Advance the shift register by one bit towards the line.
    always_comb begin
        shift_adv = MSB_FIRST ? {shift_q[NUM_SIZE-2:0], 1'b0}
                              : {1'b0, shift_q[NUM_SIZE-1:1]};
    end

    // Next state, frame bookkeeping and the next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        done_d     = 1'b0;
        prog_out_d = IDLE_LEVEL;
        busy_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (bus.numValid) begin
                    state_d = ST_START;
                    shift_d = bus.numIn;
                end
            end
            ST_START: begin
                if (period_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (period_end) begin
                    shift_d = shift_adv;
                    if (idx_q == DATA_LAST) begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                // done is registered, so it is set one cycle ahead to land on
                // the last cycle of the final stop bit (BIT_CLKS >= 2).
                if (period_near_end && (idx_q == STOP_LAST)) begin
                    done_d = 1'b1;
                end
                if (period_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The line level follows the state being entered, so it changes on the same edge as the state.
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START: prog_out_d = START_LEVEL;
            ST_DATA:  prog_out_d = MSB_FIRST ? shift_d[NUM_SIZE-1] : shift_d[0];
            default:  prog_out_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            prog_out_q <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            prog_out_q <= prog_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.numReady = (state_q == ST_IDLE);
    assign bus.progOut  = prog_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_prog_num_encoder.sv
// tb_prog_num_encoder: checks the programming-line encoder against a frame model.
// Instance a uses an 8-bit number, a 4-cycle bit period and 2 stop bits.
// Instance l uses a 1000-cycle bit period.
module tb_prog_num_encoder;
    localparam int NS   = 8;
    localparam int BC_A = 4;
    localparam int SB_A = 2;
    localparam int BC_L = 1000;
    localparam int SB_L = 2;
    localparam int FL_A = (1 + NS + SB_A) * BC_A;
    localparam int FL_L = (1 + NS + SB_L) * BC_L;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    prog_num_encoder_if #(.NUM_SIZE(NS)) bus_a ();
    prog_num_encoder_if #(.NUM_SIZE(NS)) bus_l ();

    prog_num_encoder #(
        .NUM_SIZE(NS), .BIT_CLKS(BC_A), .BIT_CNT_SIZE(16), .STOP_BITS(SB_A)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    prog_num_encoder #(
        .NUM_SIZE(NS), .BIT_CLKS(BC_L), .BIT_CNT_SIZE(16), .STOP_BITS(SB_L)
    ) dut_l (
        .clk(clk), .rst(rst), .bus(bus_l)
    );

    // Expected {progOut, busy, done, numReady} k cycles after the accept edge.
    // Bit 0 is the start bit, bits 1..NS are data bits sent MSB first, and the rest are stop bits.
    function automatic logic [3:0] exp_out(int k, logic [7:0] v, int bc, int sb);
        int   fl;
        int   b;
        logic p;
        fl = (1 + NS + sb) * bc;
        if (k < 1 || k > fl) return 4'b0001;
        b = (k - 1) / bc;
        if (b == 0)       p = 1'b1;
        else if (b <= NS) p = v[NS - b];
        else              p = 1'b0;
        return {p, 1'b1, (k == fl), 1'b0};
    endfunction

    task automatic test_reset();
        n_vec++; if (bus_a.progOut !== 1'b0)  begin n_err++; $display("FAIL reset progOut got %b want 0", bus_a.progOut); end
        n_vec++; if (bus_a.busy !== 1'b0)     begin n_err++; $display("FAIL reset busy got %b want 0", bus_a.busy); end
        n_vec++; if (bus_a.done !== 1'b0)     begin n_err++; $display("FAIL reset done got %b want 0", bus_a.done); end
        n_vec++; if (bus_a.numReady !== 1'b1) begin n_err++; $display("FAIL reset numReady got %b want 1", bus_a.numReady); end
        n_vec++; if (bus_l.progOut !== 1'b0)  begin n_err++; $display("FAIL reset_l progOut got %b want 0", bus_l.progOut); end
        n_vec++; if (bus_l.numReady !== 1'b1) begin n_err++; $display("FAIL reset_l numReady got %b want 1", bus_l.numReady); end
    endtask

    // Single frames with one-cycle requests; numIn is scrambled after accept.
    task automatic test_single_frames();
        logic [7:0] vals[$];
        logic [3:0] e;
        logic [3:0] o;
        vals = '{8'hA5, 8'h00, 8'h7F, 8'hFF};
        for (int i = 0; i < 4; i++) vals.push_back(8'($urandom));
        foreach (vals[i]) begin
            bus_a.numIn    = vals[i];
            bus_a.numValid = 1'b1;
            @(posedge clk);
            for (int k = 1; k <= FL_A + 1; k++) begin
                @(negedge clk);
                e = exp_out(k, vals[i], BC_A, SB_A);
                o = {bus_a.progOut, bus_a.busy, bus_a.done, bus_a.numReady};
                n_vec++;
                if (o !== e) begin
                    n_err++;
                    $display("FAIL frame v=%h k=%0d {prog,busy,done,rdy} got %b want %b", vals[i], k, o, e);
                end
                if (k == 1) begin
                    bus_a.numValid = 1'b0;
                    bus_a.numIn    = 8'($urandom);
                end
            end
        end
    endtask

    // numValid is held high across two frames, so the second frame is accepted on the first ready cycle.
    task automatic test_back_to_back();
        logic [3:0] e;
        logic [3:0] o;
        int run;
        int best;
        run  = 0;
        best = 0;
        bus_a.numIn    = 8'h01;
        bus_a.numValid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * FL_A + 2; k++) begin
            @(negedge clk);
            if (k <= FL_A + 1) e = exp_out(k, 8'h01, BC_A, SB_A);
            else               e = exp_out(k - FL_A - 1, 8'hFF, BC_A, SB_A);
            o = {bus_a.progOut, bus_a.busy, bus_a.done, bus_a.numReady};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b k=%0d {prog,busy,done,rdy} got %b want %b", k, o, e);
            end
            if (k > FL_A + 1) begin
                run  = bus_a.progOut ? run + 1 : 0;
                best = (run > best) ? run : best;
            end
            if (k == 1)        bus_a.numIn    = 8'hFF;
            if (k == FL_A + 2) bus_a.numValid = 1'b0;
        end
        n_vec++;
        if (best != (1 + NS) * BC_A) begin
            n_err++;
            $display("FAIL b2b_ff_high_run got %0d want %0d", best, (1 + NS) * BC_A);
        end
    endtask

    // A request pulsed while a frame is in flight must be dropped.
    task automatic test_busy_request();
        logic [3:0] e;
        logic [3:0] o;
        bus_a.numIn    = 8'h80;
        bus_a.numValid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= FL_A + 12; k++) begin
            @(negedge clk);
            e = exp_out(k, 8'h80, BC_A, SB_A);
            o = {bus_a.progOut, bus_a.busy, bus_a.done, bus_a.numReady};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL busy_req k=%0d {prog,busy,done,rdy} got %b want %b", k, o, e);
            end
            if (k == 1)  bus_a.numValid = 1'b0;
            if (k == 20) begin bus_a.numIn = 8'h3C; bus_a.numValid = 1'b1; end
            if (k == 24) bus_a.numValid = 1'b0;
        end
    endtask

    // Asynchronous reset while the line is high: it must drop at once and no done may follow.
    task automatic test_reset_mid_frame();
        logic [3:0] e;
        logic [3:0] o;
        bus_a.numIn    = 8'hA5;
        bus_a.numValid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            e = exp_out(k, 8'hA5, BC_A, SB_A);
            o = {bus_a.progOut, bus_a.busy, bus_a.done, bus_a.numReady};
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pre_rst k=%0d {prog,busy,done,rdy} got %b want %b", k, o, e);
            end
            if (k == 1) bus_a.numValid = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_vec++; if (bus_a.progOut !== 1'b0) begin n_err++; $display("FAIL rst_async progOut got %b want 0", bus_a.progOut); end
        n_vec++; if (bus_a.busy !== 1'b0)    begin n_err++; $display("FAIL rst_async busy got %b want 0", bus_a.busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < FL_A + 8; k++) begin
            @(negedge clk);
            o = {bus_a.progOut, bus_a.busy, bus_a.done, bus_a.numReady};
            n_vec++;
            if (o !== 4'b0001) begin
                n_err++;
                $display("FAIL post_rst k=%0d {prog,busy,done,rdy} got %b want 0001", k, o);
            end
        end
    endtask

    // Long bit period: check the line cycle by cycle, then check the spacing of its edges.
    task automatic test_long_period();
        logic [3:0] e;
        int   edges[$];
        int   done_k;
        logic prev;
        prev   = 1'b0;
        done_k = -1;
        bus_l.numIn    = 8'h55;
        bus_l.numValid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= FL_L + 1; k++) begin
            @(negedge clk);
            e = exp_out(k, 8'h55, BC_L, SB_L);
            n_vec++;
            if ({bus_l.progOut, bus_l.done} !== {e[3], e[1]}) begin
                n_err++;
                $display("FAIL long k=%0d {prog,done} got %b%b want %b%b", k, bus_l.progOut, bus_l.done, e[3], e[1]);
            end
            if (bus_l.progOut !== prev) edges.push_back(k);
            prev = bus_l.progOut;
            if (bus_l.done === 1'b1) done_k = k;
            if (k == 1) bus_l.numValid = 1'b0;
        end
        n_vec++;
        if (edges.size() != 10) begin
            n_err++;
            $display("FAIL long_edge_count got %0d want 10", edges.size());
        end
        for (int i = 1; i < edges.size(); i++) begin
            n_vec++;
            if (edges[i] - edges[i-1] != BC_L) begin
                n_err++;
                $display("FAIL long_bit_len edge %0d got %0d want %0d", i, edges[i] - edges[i-1], BC_L);
            end
        end
        n_vec++;
        if (edges.size() == 0 || done_k - edges[0] + 1 != FL_L) begin
            n_err++;
            $display("FAIL long_frame_len got %0d want %0d", (edges.size() == 0) ? -1 : done_k - edges[0] + 1, FL_L);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus_a.numIn    = '0;
        bus_a.numValid = 1'b0;
        bus_l.numIn    = '0;
        bus_l.numValid = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_single_frames();
        test_back_to_back();
        @(negedge clk);
        test_busy_request();
        test_reset_mid_frame();
        test_long_period();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
